// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one packet-memory port between
// N_REQ requesters. Only one access is in flight at a time. Each access runs
// IDLE -> ACCESS (LAT+1 cycles) -> DONE.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   req_i        per-requester level request, held until ack
//   we_i         per-requester write enable
//   addr_i       per-requester byte address, requester k at [32k+31:32k]
//   width_i      per-requester access width, passed through unmodified
//   wdata_i      per-requester write data
//   ack_o        one-hot, one-cycle completion pulse (DONE state)
//   rdata_o      read data of the last completed read, registered
//   busy_o       high whenever the FSM is not IDLE
//   mem_ce_o     memory chip enable, high only in ACCESS
//   mem_we_o     memory write enable
//   mem_addr_o   memory address
//   mem_width_o  memory access width
//   mem_data_o   memory write data
//   mem_data_i   memory read data
module mem_arbiter #(
  parameter int N_REQ = 4,
  parameter int LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [N_REQ-1:0]     we_i,
  input  logic [N_REQ*32-1:0]  addr_i,
  input  logic [N_REQ*4-1:0]   width_i,
  input  logic [N_REQ*32-1:0]  wdata_i,
  output logic [N_REQ-1:0]     ack_o,
  output logic [31:0]          rdata_o,
  output logic                 busy_o,
  output logic                 mem_ce_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [3:0]           mem_width_o,
  output logic [31:0]          mem_data_o,
  input  logic [31:0]          mem_data_i
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     g_q;
  logic [CW-1:0]     cnt_q;
  logic [N_REQ-1:0]  ack_q;
  logic [31:0]       rdata_q;
  logic              mem_ce_q;
  logic              mem_we_q;
  logic [31:0]       mem_addr_q;
  logic [3:0]        mem_width_q;
  logic [31:0]       mem_data_q;

  // Grant candidate and its request fields, valid whenever req_i != 0.
  logic [PW-1:0]     gnt_d;
  logic              sel_we_d;
  logic [31:0]       sel_addr_d;
  logic [3:0]        sel_width_d;
  logic [31:0]       sel_wdata_d;

  // Round-robin search: first set request starting at ptr_q, wrapping.
  always_comb begin
    int gi;
    int idx;
    logic found;
    gi    = int'(ptr_q);
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        gi    = idx;
      end
    end
    gnt_d       = PW'(gi);
    sel_we_d    = we_i[gi];
    sel_addr_d  = addr_i[32*gi +: 32];
    sel_width_d = width_i[4*gi +: 4];
    sel_wdata_d = wdata_i[32*gi +: 32];
  end

  // The mem_* output registers double as the latched copy of the granted
  // request, so they stay stable through ACCESS and are zero elsewhere.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      g_q         <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_width_q <= '0;
      mem_data_q  <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            g_q         <= gnt_d;
            cnt_q       <= '0;
            mem_ce_q    <= 1'b1;
            mem_we_q    <= sel_we_d;
            mem_addr_q  <= sel_addr_d;
            mem_width_q <= sel_width_d;
            mem_data_q  <= sel_wdata_d;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q != CW'(LAT)) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            ack_q <= N_REQ'(1) << g_q;
            if (!mem_we_q) rdata_q <= mem_data_i;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_width_q <= '0;
            mem_data_q  <= '0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // req_i is ignored here so the requester can drop it after ack.
          ptr_q   <= (g_q == PW'(N_REQ - 1)) ? '0 : g_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  assign busy_o      = (state_q != IDLE);
  assign mem_ce_o    = mem_ce_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_width_o = mem_width_q;
  assign mem_data_o  = mem_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (N_REQ=4, LAT=1) with a small
// one-cycle-latency SRAM model attached to the memory port.
module tb_mem_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_i;
  logic [N-1:0]  we_i;
  logic [N*32-1:0] addr_i;
  logic [N*4-1:0]  width_i;
  logic [N*32-1:0] wdata_i;
  logic [N-1:0]  ack_o;
  logic [31:0]   rdata_o;
  logic          busy_o;
  logic          mem_ce_o;
  logic          mem_we_o;
  logic [31:0]   mem_addr_o;
  logic [3:0]    mem_width_o;
  logic [31:0]   mem_data_o;
  logic [31:0]   mem_data_i;

  logic [31:0] a [N];
  logic [31:0] d [N];
  logic [3:0]  w [N];

  logic [31:0] sram [16];
  logic [31:0] sram_q;

  int n_cmp;
  int n_err;

  assign addr_i     = {a[3], a[2], a[1], a[0]};
  assign wdata_i    = {d[3], d[2], d[1], d[0]};
  assign width_i    = {w[3], w[2], w[1], w[0]};
  assign mem_data_i = sram_q;

  mem_arbiter #(.N_REQ(N), .LAT(1)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .width_i(width_i), .wdata_i(wdata_i), .ack_o(ack_o), .rdata_o(rdata_o),
    .busy_o(busy_o), .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_width_o(mem_width_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read SRAM; word 1 is preloaded while reset is held.
  always @(posedge clk) begin
    if (!rst) begin
      sram[1] <= 32'h11223344;
    end else if (mem_ce_o) begin
      if (mem_we_o) sram[mem_addr_o[5:2]] <= mem_data_o;
      else          sram_q <= sram[mem_addr_o[5:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a nonzero ack; returns 0 if none arrives.
  task automatic wait_ack(output logic [N-1:0] ak);
    ak = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack_o != '0) begin
        ak = ack_o;
        return;
      end
    end
  endtask

  logic [N-1:0] ak;
  logic [N-1:0] ack_seq [5];
  int           t_seq [5];
  int           nack;
  int           idle_cnt;

  initial begin
    n_cmp = 0;
    n_err = 0;
    sram_q = '0;
    for (int k = 0; k < 16; k++) sram[k] = '0;
    for (int k = 0; k < N; k++) begin
      a[k] = 32'h40 + 32'(k) * 4;
      d[k] = 32'hA0A0_0000 + 32'(k);
      w[k] = 4'hF;
    end
    we_i  = '0;
    req_i = 4'b1111;
    rst   = 1'b1;
    #1 rst = 1'b0;

    // 1. Reset with all requests pending
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_ack", 32'(ack_o), 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      chk("rst_ce", 32'(mem_ce_o), 32'h0);
      chk("rst_addr", mem_addr_o, 32'h0);
    end
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_we", 32'(mem_we_o), 32'h0);
    chk("rst_width", 32'(mem_width_o), 32'h0);
    chk("rst_wdata", mem_data_o, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("first_ce", 32'(mem_ce_o), 32'h1);
    chk("first_addr", mem_addr_o, 32'h40);
    req_i = '0;                        // drop mid-ACCESS: must still complete
    wait_ack(ak);
    chk("first_grant", 32'(ak), 32'h1);
    @(negedge clk);

    // 2. Single read by requester 1 from addr 4
    a[1] = 32'd4; we_i = 4'b0000; req_i = 4'b0010;
    @(negedge clk);
    chk("rd_ce_e0", 32'(mem_ce_o), 32'h1);
    chk("rd_addr_e0", mem_addr_o, 32'h4);
    chk("rd_we_e0", 32'(mem_we_o), 32'h0);
    chk("rd_width_e0", 32'(mem_width_o), 32'hF);
    chk("rd_ack_e0", 32'(ack_o), 32'h0);
    chk("rd_busy_e0", 32'(busy_o), 32'h1);
    @(negedge clk);
    chk("rd_ce_e1", 32'(mem_ce_o), 32'h1);
    chk("rd_addr_e1", mem_addr_o, 32'h4);
    chk("rd_ack_e1", 32'(ack_o), 32'h0);
    @(negedge clk);
    chk("rd_ack_e2", 32'(ack_o), 32'h2);
    chk("rd_data", rdata_o, 32'h11223344);
    chk("rd_ce_done", 32'(mem_ce_o), 32'h0);
    chk("rd_addr_done", mem_addr_o, 32'h0);
    req_i = '0;
    @(negedge clk);
    chk("rd_ack_e3", 32'(ack_o), 32'h0);
    chk("rd_busy_idle", 32'(busy_o), 32'h0);

    // 3. Requester 3 writes addr 8, then reads it back
    a[3] = 32'd8; d[3] = 32'hDEADBEEF; we_i = 4'b1000; req_i = 4'b1000;
    @(negedge clk);
    chk("wr_we_e0", 32'(mem_we_o), 32'h1);
    chk("wr_data_e0", mem_data_o, 32'hDEADBEEF);
    chk("wr_addr_e0", mem_addr_o, 32'h8);
    d[3] = 32'h0BAD0BAD;               // late field change has no effect
    @(negedge clk);
    chk("wr_we_e1", 32'(mem_we_o), 32'h1);
    chk("wr_data_e1", mem_data_o, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_ack", 32'(ack_o), 32'h8);
    chk("wr_rdata_hold", rdata_o, 32'h11223344);
    chk("wr_we_done", 32'(mem_we_o), 32'h0);
    req_i = '0;
    @(negedge clk);
    chk("wr_sram", sram[2], 32'hDEADBEEF);
    we_i = 4'b0000; req_i = 4'b1000;
    wait_ack(ak);
    chk("rb_ack", 32'(ak), 32'h8);
    chk("rb_data", rdata_o, 32'hDEADBEEF);
    req_i = '0;
    @(negedge clk);

    // 4. Full contention, round-robin order and spacing
    req_i = 4'b1111;
    nack = 0;
    idle_cnt = 0;
    for (int c = 1; c <= 60 && nack < 5; c++) begin
      @(negedge clk);
      if (!busy_o && nack >= 1) idle_cnt++;
      if (ack_o != '0) begin
        ack_seq[nack] = ack_o;
        t_seq[nack]   = c;
        nack++;
        if (nack == 5) req_i = '0;
      end
    end
    chk("rr_count", 32'(nack), 32'd5);
    chk("rr_ack0", 32'(ack_seq[0]), 32'h1);
    chk("rr_ack1", 32'(ack_seq[1]), 32'h2);
    chk("rr_ack2", 32'(ack_seq[2]), 32'h4);
    chk("rr_ack3", 32'(ack_seq[3]), 32'h8);
    chk("rr_ack4", 32'(ack_seq[4]), 32'h1);
    for (int k = 1; k < 5; k++) chk("rr_gap", 32'(t_seq[k] - t_seq[k-1]), 32'd4);
    chk("rr_idle", 32'(idle_cnt), 32'd4);
    @(negedge clk);

    // 5. Wrap priority: grant 2 (ptr=3), then 0101 -> 0 then 2
    req_i = 4'b0100;
    wait_ack(ak);
    chk("wrap_pre", 32'(ak), 32'h4);
    req_i = '0;
    @(negedge clk);
    req_i = 4'b0101;
    wait_ack(ak);
    chk("wrap_g0", 32'(ak), 32'h1);
    req_i = 4'b0100;
    wait_ack(ak);
    chk("wrap_g2", 32'(ak), 32'h4);
    req_i = '0;
    @(negedge clk);

    // 6. Asynchronous reset in the second ACCESS cycle of a write
    a[0] = 32'd12; d[0] = 32'h5555AAAA; we_i = 4'b0001; req_i = 4'b0001;
    @(negedge clk);
    chk("ar_ce_e0", 32'(mem_ce_o), 32'h1);
    @(negedge clk);
    chk("ar_ce_e1", 32'(mem_ce_o), 32'h1);
    chk("ar_we_e1", 32'(mem_we_o), 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("ar_ce_async", 32'(mem_ce_o), 32'h0);
    chk("ar_we_async", 32'(mem_we_o), 32'h0);
    chk("ar_busy_async", 32'(busy_o), 32'h0);
    req_i = '0; we_i = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("ar_no_ack", 32'(ack_o), 32'h0);
    end
    rst = 1'b1;
    req_i = 4'b1010;                   // ptr=0 grants 1; a stale ptr=3 would grant 3
    wait_ack(ak);
    chk("ar_ptr0", 32'(ak), 32'h2);
    req_i = '0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
